// File: rtl/result_arbiter_if.sv
// Completion-broadcast bundle shared by the result producers and the result arbiter.
// slave = arbiter side, master = producers/consumer (or testbench) side.
interface result_arbiter_if #(
   parameter int N_REQ    = 5,
   parameter int RESULT_W = 64
);
   logic [N_REQ-1:0]          req_en;
   logic [N_REQ*RESULT_W-1:0] req_msg;
   logic [N_REQ-1:0]          req_reject;
   logic                      out_en;
   logic [RESULT_W-1:0]       out_msg;
   logic                      out_reject;

   modport slave (
      input  req_en,
      input  req_msg,
      input  out_reject,
      output req_reject,
      output out_en,
      output out_msg
   );

   modport master (
      output req_en,
      output req_msg,
      output out_reject,
      input  req_reject,
      input  out_en,
      input  out_msg
   );
endinterface

// File: rtl/result_arbiter.sv
// Round-robin arbiter sharing the single writeback broadcast between result producers.
// Optional RESULT_ARB_BYPASS_EN: 0-cycle combinational path when the output register is empty.
module result_arbiter #(
   parameter int N_REQ    = 5,
   parameter int RESULT_W = 64,
   parameter int PTR_W    = 3
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             flash,
   result_arbiter_if.slave  bus
);
   logic                   out_valid_reg, out_valid_next;
   logic [RESULT_W-1:0]    out_data_reg, out_data_next;
   logic [PTR_W-1:0]       ptr_reg, ptr_next;

   logic                   can_load;
   logic [N_REQ-1:0]       grant;
   logic                   grant_found;
   logic [PTR_W-1:0]       grant_idx;
   logic [PTR_W:0]         scan_sum;
   logic                   bypass_grant;
   logic [RESULT_W-1:0]    msg_arr [N_REQ];

   genvar gi;
   generate
      for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
         assign msg_arr[gi] = bus.req_msg[gi*RESULT_W +: RESULT_W];
      end
   endgenerate

   assign can_load = ~out_valid_reg | ~bus.out_reject;

   // Rotating scan from ptr; the extra sum bit lets the wrap be a single subtract.
   always_comb begin
      grant       = '0;
      grant_found = 1'b0;
      grant_idx   = '0;
      scan_sum    = '0;
      if (!reset && can_load && !flash) begin
         for (int j = 0; j < N_REQ; j++) begin
            scan_sum = {1'b0, ptr_reg} + (PTR_W+1)'(j);
            if (scan_sum >= (PTR_W+1)'(N_REQ))
               scan_sum = scan_sum - (PTR_W+1)'(N_REQ);
            if (!grant_found && bus.req_en[scan_sum[PTR_W-1:0]]) begin
               grant_found = 1'b1;
               grant_idx   = scan_sum[PTR_W-1:0];
            end
         end
         if (grant_found)
            grant[grant_idx] = 1'b1;
      end
   end

   assign bus.req_reject = ~grant;

`ifdef RESULT_ARB_BYPASS_EN
   // Empty register and a ready consumer: hand the winner straight through.
   assign bypass_grant = grant_found & ~out_valid_reg & ~bus.out_reject;
   assign bus.out_msg  = bypass_grant ? msg_arr[grant_idx] : out_data_reg;
`else
   assign bypass_grant = 1'b0;
   assign bus.out_msg  = out_data_reg;
`endif

   assign bus.out_en = (out_valid_reg | bypass_grant) & ~flash & ~reset;

   always_comb begin
      out_valid_next = out_valid_reg;
      out_data_next  = out_data_reg;
      ptr_next       = ptr_reg;
      if (flash) begin
         out_valid_next = 1'b0;
      end else if (grant_found) begin
         ptr_next = (grant_idx == PTR_W'(N_REQ-1)) ? '0 : grant_idx + PTR_W'(1);
         if (bypass_grant) begin
            out_valid_next = 1'b0;
         end else begin
            out_data_next  = msg_arr[grant_idx];
            out_valid_next = 1'b1;
         end
      end else if (!bus.out_reject) begin
         out_valid_next = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         ptr_reg       <= '0;
      end else begin
         out_valid_reg <= out_valid_next;
         out_data_reg  <= out_data_next;
         ptr_reg       <= ptr_next;
      end
   end
endmodule

// File: tb/tb_result_arbiter.sv
// Self-checking bench for result_arbiter: directed steps plus random traffic against
// a cycle-level reference model of the round-robin/writeback rules.
module tb_result_arbiter;
   localparam int N = 5;
   localparam int W = 64;
`ifdef RESULT_ARB_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clock;
   logic reset;
   logic flash;

   result_arbiter_if #(.N_REQ(N), .RESULT_W(W)) bus ();

   result_arbiter #(.N_REQ(N), .RESULT_W(W), .PTR_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .flash (flash),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int          n_cmp = 0;
   int          n_bad = 0;
   logic [W-1:0] msg_m [N];
   bit          ov_m = 1'b0;
   logic [W-1:0] reg_m = '0;
   int          ptr_m = 0;
   logic [N-1:0] last_rej;
   logic        last_en;
   logic [N-1:0] want;

   task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
      n_cmp++;
      assert (obs === expv) else begin
         n_bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
      end
   endtask

   // One clock cycle: drive, check combinational outputs mid-cycle, advance the model.
   task automatic step(input logic [N-1:0] en, input logic rej, input logic fl, input logic rs);
      int k;
      logic [N-1:0] exp_rej;
      logic byp;
      logic exp_en;
      logic [W-1:0] exp_msg;
      bus.req_en     = en;
      bus.out_reject = rej;
      flash          = fl;
      reset          = rs;
      for (int i = 0; i < N; i++) bus.req_msg[i*W +: W] = msg_m[i];
      @(negedge clock);
      k = -1;
      if (!rs && !fl && (!ov_m || !rej))
         for (int j = 0; j < N; j++)
            if (k < 0 && en[(ptr_m + j) % N]) k = (ptr_m + j) % N;
      exp_rej = '1;
      if (k >= 0) exp_rej[k] = 1'b0;
      byp     = BYP && (k >= 0) && !ov_m && !rej;
      exp_en  = (ov_m || byp) && !fl && !rs;
      exp_msg = byp ? msg_m[k] : reg_m;
      chk("req_reject", W'(bus.req_reject), W'(exp_rej));
      chk("out_en", W'(bus.out_en), W'(exp_en));
      if (!rs) chk("out_msg", bus.out_msg, exp_msg);
      last_rej = bus.req_reject;
      last_en  = bus.out_en;
      @(posedge clock);
      if (rs) begin
         ov_m = 1'b0; reg_m = '0; ptr_m = 0;
      end else if (fl) begin
         ov_m = 1'b0;
      end else if (k >= 0) begin
         ptr_m = (k + 1) % N;
         if (byp) ov_m = 1'b0;
         else begin reg_m = msg_m[k]; ov_m = 1'b1; end
      end else if (!rej) begin
         ov_m = 1'b0;
      end
      #1;
   endtask

   initial begin
      for (int i = 0; i < N; i++) msg_m[i] = '0;
      bus.req_en = '0; bus.req_msg = '0; bus.out_reject = 1'b0;
      flash = 1'b0; reset = 1'b1;

      // Reset: all rejects high, out_en low
      step(5'b00000, 1'b0, 1'b0, 1'b1);
      step(5'b11111, 1'b0, 1'b0, 1'b1);
      chk("reset_rej", W'(last_rej), W'(5'b11111));
      chk("reset_en", W'(last_en), W'(1'b0));

      // Single requester
      msg_m[0] = 64'hA1;
      step(5'b00001, 1'b0, 1'b0, 1'b0);
      chk("single_rej", W'(last_rej), W'(5'b11110));
`ifdef RESULT_ARB_BYPASS_EN
      chk("single_byp_en", W'(last_en), W'(1'b1));
`else
      chk("single_en_next", W'(bus.out_en), W'(1'b1));
      chk("single_msg_next", bus.out_msg, 64'hA1);
`endif
      step(5'b00000, 1'b0, 1'b0, 1'b0);

      // All active: grants 0..4 in order
      step(5'b00000, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < N; i++) msg_m[i] = 64'h10 + W'(i);
      for (int i = 0; i < N; i++) begin
         step(5'b11111, 1'b0, 1'b0, 1'b0);
         want = ~(N'(1) << i);
         chk("rr_grant", W'(last_rej), W'(want));
      end
      step(5'b00000, 1'b0, 1'b0, 1'b0);

      // Backpressure: load 0x20 under stall, hold, then consume+reload without a bubble
      msg_m[0] = 64'h20; msg_m[2] = 64'h22;
      step(5'b00001, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(5'b00100, 1'b1, 1'b0, 1'b0);
         chk("bp_rej", W'(last_rej), W'(5'b11111));
         chk("bp_hold", bus.out_msg, 64'h20);
      end
      step(5'b00100, 1'b0, 1'b0, 1'b0);
      chk("bp_grant2", W'(last_rej), W'(5'b11011));
      chk("bp_reload", bus.out_msg, 64'h22);
      chk("bp_no_bubble", W'(bus.out_en), W'(1'b1));

      // Flash during stall
      step(5'b00100, 1'b1, 1'b1, 1'b0);
      chk("flash_en", W'(last_en), W'(1'b0));
      chk("flash_rej", W'(last_rej), W'(5'b11111));
      step(5'b00000, 1'b1, 1'b0, 1'b0);
      chk("flash_cleared", W'(last_en), W'(1'b0));

      // Skip and wrap from ptr=4
      step(5'b00000, 1'b0, 1'b0, 1'b1);
      msg_m[1] = 64'h51; msg_m[3] = 64'h53;
      step(5'b01000, 1'b0, 1'b0, 1'b0);
      step(5'b01010, 1'b0, 1'b0, 1'b0);
      chk("skip_grant1", W'(last_rej), W'(5'b11101));
      step(5'b01010, 1'b0, 1'b0, 1'b0);
      chk("skip_grant3", W'(last_rej), W'(5'b10111));
      step(5'b00000, 1'b0, 1'b0, 1'b0);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) msg_m[i] = {$urandom, $urandom};
         step(N'($urandom), ($urandom_range(0, 9) < 3), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 99) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
